// File: rtl/io_tx_prefetch_pkg.sv
// Shared types and default sizing for the TX prefetch block.
package io_tx_prefetch_pkg;

   localparam int unsigned DATA_WIDTH_DEF       = 32;
   localparam int unsigned BUFFER_DEPTH_DEF     = 4;
   localparam int unsigned LOG_BUFFER_DEPTH_DEF = $clog2(BUFFER_DEPTH_DEF);
   localparam int unsigned CNT_WIDTH_DEF        = LOG_BUFFER_DEPTH_DEF + 1;
   localparam int unsigned LEN_WIDTH_DEF        = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FLUSH = 2'd3
   } state_e;

endpackage

// File: rtl/io_tx_prefetch_buf.sv
// Storage ring for prefetched words: one write port, one pop port, clear.
module io_tx_prefetch_buf
   import io_tx_prefetch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
   parameter int unsigned BUFFER_DEPTH     = BUFFER_DEPTH_DEF,
   parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clr_i,
   input  logic                        wr_en_i,
   input  logic [DATA_WIDTH-1:0]       wr_data_i,
   input  logic                        rd_en_i,
   output logic [DATA_WIDTH-1:0]       data_o,
   output logic                        valid_o,
   output logic [LOG_BUFFER_DEPTH:0]   elements_o
);

   localparam int unsigned CNT_W = LOG_BUFFER_DEPTH + 1;
   localparam logic [LOG_BUFFER_DEPTH-1:0] LAST_PTR = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);

   logic [DATA_WIDTH-1:0]       mem_q [BUFFER_DEPTH];
   logic [DATA_WIDTH-1:0]       mem_d [BUFFER_DEPTH];
   logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_BUFFER_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]            elements_q, elements_d;
   logic                        pop;

   assign pop = rd_en_i && (elements_q != '0);

   // Next-state for storage, pointers (wrapping at BUFFER_DEPTH-1) and count.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      elements_d = elements_q;
      if (clr_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         elements_d = '0;
      end else begin
         if (wr_en_i) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + LOG_BUFFER_DEPTH'(1);
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + LOG_BUFFER_DEPTH'(1);
         end
         case ({wr_en_i, pop})
            2'b10:   elements_d = elements_q + CNT_W'(1);
            2'b01:   elements_d = elements_q - CNT_W'(1);
            default: elements_d = elements_q;
         endcase
      end
   end

   // Storage and pointer registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         elements_q <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         elements_q <= elements_d;
      end
   end

   assign data_o     = mem_q[rd_ptr_q];
   assign valid_o    = (elements_q != '0);
   assign elements_o = elements_q;

endmodule

// File: rtl/io_tx_prefetch.sv
// Credit-limited L2 read prefetcher feeding a valid/ready TX stream.
module io_tx_prefetch
   import io_tx_prefetch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
   parameter int unsigned BUFFER_DEPTH     = BUFFER_DEPTH_DEF,
   parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH),
   parameter int unsigned LEN_WIDTH        = LEN_WIDTH_DEF
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clr_i,
   input  logic                        start_i,
   input  logic [LEN_WIDTH-1:0]        len_i,
   output logic                        busy_o,
   output logic                        req_o,
   input  logic                        gnt_i,
   input  logic                        r_valid_i,
   input  logic [DATA_WIDTH-1:0]       r_data_i,
   output logic [DATA_WIDTH-1:0]       data_o,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [LOG_BUFFER_DEPTH:0]   elements_o,
   output logic [LOG_BUFFER_DEPTH:0]   outstanding_o
);

   localparam int unsigned CNT_W = LOG_BUFFER_DEPTH + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0]     outstanding_q, outstanding_d;
   logic [CNT_W-1:0]     elements;
   logic [SUM_W-1:0]     credit_used;
   logic                 grant;
   logic                 rsp;
   logic                 pop;
   logic                 wr_en;

   // Credit: stored plus in-flight words may not exceed the buffer depth.
   assign credit_used = SUM_W'(elements) + SUM_W'(outstanding_q);
   assign req_o       = (state_q == RUN) && (credit_used < SUM_W'(BUFFER_DEPTH));
   assign grant       = req_o && gnt_i;
   assign rsp         = r_valid_i && (outstanding_q != '0);
   assign pop         = valid_o && ready_i;
   assign wr_en       = rsp && (state_q != FLUSH) && !clr_i;

   // In-flight request counter; a response with nothing outstanding is dropped.
   always_comb begin
      outstanding_d = outstanding_q;
      case ({grant, rsp})
         2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
         2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase
   end

   // Transfer FSM and remaining-word counter; clear overrides everything.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      if (clr_i) begin
         remaining_d = '0;
         state_d     = (outstanding_d != '0) ? FLUSH : IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i && (len_i != '0)) begin
                  state_d     = RUN;
                  remaining_d = len_i;
               end
            end
            RUN: begin
               if (grant && (remaining_q != '0)) begin
                  remaining_d = remaining_q - LEN_WIDTH'(1);
                  if (remaining_q == LEN_WIDTH'(1)) begin
                     state_d = DRAIN;
                  end
               end
            end
            DRAIN, FLUSH: begin
               if (outstanding_q == '0) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Control registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         remaining_q   <= '0;
         outstanding_q <= '0;
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         outstanding_q <= outstanding_d;
      end
   end

   io_tx_prefetch_buf #(
      .DATA_WIDTH       (DATA_WIDTH),
      .BUFFER_DEPTH     (BUFFER_DEPTH),
      .LOG_BUFFER_DEPTH (LOG_BUFFER_DEPTH)
   ) u_buf (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (clr_i),
      .wr_en_i    (wr_en),
      .wr_data_i  (r_data_i),
      .rd_en_i    (pop),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .elements_o (elements)
   );

   assign busy_o        = (state_q != IDLE);
   assign elements_o    = elements;
   assign outstanding_o = outstanding_q;

   // Memory-side protocol and credit invariants.
   a_rsp_needs_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
      r_valid_i |-> (outstanding_q != '0));
   a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      credit_used <= SUM_W'(BUFFER_DEPTH));

endmodule

// File: tb/tb_io_tx_prefetch.sv
// Self-checking bench: queue-based reference model plus memory responder.
module tb_io_tx_prefetch;

   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam int LW = 16;
   localparam int CW = 3;
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_FLUSH = 3;

   logic          clk_i = 1'b0;
   logic          rst_i, clr_i, start_i, gnt_i, r_valid_i, ready_i;
   logic [LW-1:0] len_i;
   logic [DW-1:0] r_data_i, data_o;
   logic          busy_o, req_o, valid_o;
   logic [CW-1:0] elements_o, outstanding_o;

   always #5 clk_i = ~clk_i;

   io_tx_prefetch #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .start_i(start_i), .len_i(len_i),
      .busy_o(busy_o), .req_o(req_o), .gnt_i(gnt_i), .r_valid_i(r_valid_i),
      .r_data_i(r_data_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .elements_o(elements_o), .outstanding_o(outstanding_o)
   );

   typedef struct { int due; logic [DW-1:0] data; } rsp_t;

   int checks = 0, failures = 0;
   int m_state, m_rem, m_outst;
   logic [DW-1:0] m_store[$];
   rsp_t mem_q[$];
   logic [DW-1:0] pop_log[$];
   int g_cyc[$];
   int cyc = 0, last_due = 0;
   int lat_min = 2, lat_max = 2;
   int gnt_mode = 0, gnt_wait = 0;
   bit rdy_rand = 0;
   logic [DW-1:0] next_data = '0;
   int n_grants = 0, n_req = 0, n_rsp = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mreset();
      m_state = M_IDLE; m_rem = 0; m_outst = 0;
      m_store.delete(); mem_q.delete(); last_due = 0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_req"}, req_o, 0);
      chk({tag, "_valid"}, valid_o, 0);
      chk({tag, "_data"}, data_o, 0);
      chk({tag, "_elements"}, elements_o, 0);
      chk({tag, "_outstanding"}, outstanding_o, 0);
   endtask

   // One clock: drive memory side, compare DUT to model, advance model.
   task automatic cycle();
      bit m_req, grant, rsp, pop;
      int nouts, due;
      r_valid_i = 1'b0;
      r_data_i  = '0;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         r_valid_i = 1'b1;
         r_data_i  = mem_q[0].data;
      end
      m_req = (m_state == M_RUN) && (m_store.size() + m_outst < DEPTH);
      case (gnt_mode)
         0:       gnt_i = 1'b1;
         1:       gnt_i = 1'($urandom_range(0, 1));
         2:       gnt_i = m_req && (gnt_wait == 0);
         default: gnt_i = 1'b0;
      endcase
      if (rdy_rand) ready_i = 1'($urandom_range(0, 1));

      chk("busy", busy_o, m_state != M_IDLE);
      chk("req", req_o, m_req);
      chk("valid", valid_o, m_store.size() != 0);
      chk("elements", elements_o, m_store.size());
      chk("outstanding", outstanding_o, m_outst);
      if (m_store.size() != 0) chk("data", data_o, m_store[0]);

      grant = m_req && gnt_i;
      rsp   = r_valid_i;
      pop   = (m_store.size() != 0) && ready_i;
      if (m_req) n_req++;
      if (grant) begin n_grants++; g_cyc.push_back(cyc); end
      if (rsp) n_rsp++;
      if (gnt_mode == 2 && m_req && !grant && gnt_wait > 0) gnt_wait--;

      if (rst_i) begin
         mreset();
      end else begin
         if (rsp) void'(mem_q.pop_front());
         if (grant) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{due: due, data: next_data});
            next_data = next_data + 1;
         end
         nouts = m_outst + int'(grant) - int'(rsp);
         if (clr_i) begin
            m_store.delete();
            m_rem = 0;
            m_state = (nouts != 0) ? M_FLUSH : M_IDLE;
         end else begin
            if (pop) pop_log.push_back(m_store.pop_front());
            if (rsp && m_state != M_FLUSH) m_store.push_back(r_data_i);
            case (m_state)
               M_IDLE: if (start_i && len_i != 0) begin m_state = M_RUN; m_rem = int'(len_i); end
               M_RUN: if (grant) begin m_rem--; if (m_rem == 0) m_state = M_DRAIN; end
               default: if (m_outst == 0) m_state = M_IDLE;
            endcase
         end
         m_outst = nouts;
      end
      @(negedge clk_i);
      cyc++;
   endtask

   task automatic run_until_idle(input int max);
      int n = 0;
      while ((m_state != M_IDLE || m_store.size() != 0) && n < max) begin
         cycle();
         n++;
      end
      chk("drain_timeout", (m_state != M_IDLE || m_store.size() != 0), 0);
   endtask

   task automatic start_xfer(input int len);
      start_i = 1'b1;
      len_i   = LW'(len);
      cycle();
      start_i = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int len;
      rst_i = 1'b1; clr_i = 1'b0; start_i = 1'b0; len_i = '0;
      gnt_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; ready_i = 1'b0;
      mreset();
      repeat (3) @(negedge clk_i);
      chk_reset_outputs("reset");
      rst_i = 1'b0;

      // Basic fetch: 3 words, 2-cycle latency, always ready.
      ready_i = 1'b1; next_data = 32'hA0; pop_log.delete(); g_cyc.delete(); n_grants = 0;
      start_xfer(3);
      run_until_idle(40);
      chk("basic_grants", n_grants, 3);
      if (g_cyc.size() == 3) begin
         chk("basic_consec0", g_cyc[1] - g_cyc[0], 1);
         chk("basic_consec1", g_cyc[2] - g_cyc[1], 1);
      end
      chk("basic_pops", pop_log.size(), 3);
      for (int i = 0; i < 3; i++)
         chk("basic_data_seq", (pop_log.size() > i) ? pop_log[i] : 'x, 32'hA0 + i);
      chk("basic_busy_low", busy_o, 0);
      chk("basic_elements", elements_o, 0);

      // Credit stall: no pops, exactly DEPTH grants, then resume after one pop.
      ready_i = 1'b0; next_data = 32'h100; pop_log.delete(); n_grants = 0;
      start_xfer(10);
      repeat (11) cycle();
      chk("stall_grants", n_grants, 4);
      chk("stall_req", req_o, 0);
      chk("stall_credit", 4'(elements_o) + 4'(outstanding_o), 4);
      ready_i = 1'b1;
      cycle();
      ready_i = 1'b0;
      chk("stall_req_resume", req_o, 1);
      rdy_rand = 1;
      run_until_idle(300);
      rdy_rand = 0; ready_i = 1'b1;
      chk("stall_total_grants", n_grants, 10);
      chk("stall_pops", pop_log.size(), 10);
      for (int i = 0; i < 10; i++)
         chk("stall_wrap_data", (pop_log.size() > i) ? pop_log[i] : 'x, 32'h100 + i);

      // Randomized transfers: random grant, latency and consumer.
      lat_min = 1; lat_max = 4; gnt_mode = 1; rdy_rand = 1;
      for (int t = 0; t < 8; t++) begin
         len = $urandom_range(1, 12);
         n_grants = 0;
         next_data = $urandom;
         start_xfer(len);
         run_until_idle(500);
         chk("rand_grants", n_grants, len);
      end
      lat_min = 2; lat_max = 2; gnt_mode = 0; rdy_rand = 0; ready_i = 1'b1;

      // Abort with two requests in flight; start during FLUSH is ignored.
      lat_min = 4; lat_max = 4; pop_log.delete();
      start_xfer(8);
      n = 0;
      while (m_outst != 2 && n < 20) begin cycle(); n++; end
      chk("abort_setup_outstanding", outstanding_o, 2);
      gnt_mode = 3; clr_i = 1'b1;
      cycle();
      clr_i = 1'b0;
      chk("abort_req", req_o, 0);
      chk("abort_busy", busy_o, 1);
      chk("abort_outstanding", outstanding_o, 2);
      chk("abort_valid", valid_o, 0);
      n_rsp = 0; n_grants = 0;
      start_xfer(5);
      run_until_idle(30);
      repeat (3) cycle();
      chk("abort_discards", n_rsp, 2);
      chk("abort_no_pops", pop_log.size(), 0);
      chk("abort_no_grants", n_grants, 0);
      chk("abort_idle", busy_o, 0);
      gnt_mode = 0; lat_min = 2; lat_max = 2;

      // Zero-length start is ignored.
      n_req = 0;
      start_xfer(0);
      repeat (5) cycle();
      chk("len0_req", n_req, 0);
      chk("len0_busy", busy_o, 0);

      // Single word with grant withheld for 4 request cycles.
      gnt_mode = 2; gnt_wait = 4; n_req = 0; n_grants = 0;
      start_xfer(1);
      n = 0;
      while (n_grants == 0 && n < 20) begin cycle(); n++; end
      chk("len1_req_cycles", n_req, 5);
      chk("len1_drain_busy", busy_o, 1);
      chk("len1_drain_req", req_o, 0);
      run_until_idle(30);
      chk("len1_grants", n_grants, 1);
      gnt_mode = 0;

      // Reset mid-RUN, then a fresh transfer.
      ready_i = 1'b0;
      start_xfer(8);
      repeat (3) cycle();
      rst_i = 1'b1;
      cycle();
      rst_i = 1'b0;
      chk_reset_outputs("midrst");
      ready_i = 1'b1; next_data = 32'hC0; pop_log.delete();
      start_xfer(3);
      run_until_idle(40);
      chk("midrst_pops", pop_log.size(), 3);
      for (int i = 0; i < 3; i++)
         chk("midrst_data_seq", (pop_log.size() > i) ? pop_log[i] : 'x, 32'hC0 + i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
